// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline package: widths, control-bundle layout and the ID/EX payload.
package id_ex_stage_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned REG_W  = 5;
   localparam int unsigned CTRL_W = 8;
   localparam int unsigned CNT_W  = 16;

   // Control bundle bit positions (MSB first, matching ctrl_t below)
   localparam int unsigned CTRL_REGWRITE  = 7;
   localparam int unsigned CTRL_MEMREAD   = 6;
   localparam int unsigned CTRL_MEMWRITE  = 5;
   localparam int unsigned CTRL_MEMTOREG  = 4;
   localparam int unsigned CTRL_ALUSRC    = 3;
   localparam int unsigned CTRL_ALUOP_LSB = 0;
   localparam int unsigned ALUOP_W        = 3;

   typedef struct packed {
      logic               reg_write;
      logic               mem_read;
      logic               mem_write;
      logic               mem_to_reg;
      logic               alu_src;
      logic [ALUOP_W-1:0] alu_op;
   } ctrl_t;

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
      logic [REG_W-1:0] rd;
      ctrl_t            ctrl;
      logic [XLEN-1:0]  rs1_data;
      logic [XLEN-1:0]  rs2_data;
      logic [XLEN-1:0]  imm;
      logic [XLEN-1:0]  pc;
   } id_ex_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID -> ID/EX bundle. Optional HAZARD_STATS_EN adds the hazard counters.
interface id_ex_stage_if;
   import id_ex_stage_pkg::*;

   logic              id_valid;
   logic [REG_W-1:0]  id_rs1;
   logic [REG_W-1:0]  id_rs2;
   logic [REG_W-1:0]  id_rd;
   logic              id_uses_rs1;
   logic              id_uses_rs2;
   logic [XLEN-1:0]   id_rs1_data;
   logic [XLEN-1:0]   id_rs2_data;
   logic [XLEN-1:0]   id_imm;
   logic [XLEN-1:0]   id_pc;
   logic [CTRL_W-1:0] id_ctrl;
   logic              ex_flush;
   logic              mem_busy;

   logic              ID_EX_valid;
   logic [REG_W-1:0]  ID_EX_rs1;
   logic [REG_W-1:0]  ID_EX_rs2;
   logic [REG_W-1:0]  ID_EX_rd;
   logic [CTRL_W-1:0] ID_EX_ctrl;
   logic [XLEN-1:0]   ID_EX_rs1_data;
   logic [XLEN-1:0]   ID_EX_rs2_data;
   logic [XLEN-1:0]   ID_EX_imm;
   logic [XLEN-1:0]   ID_EX_pc;
   logic              ID_EX_RegWrite;
   logic              ID_EX_MemRead;
   logic              stall_o;
`ifdef HAZARD_STATS_EN
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  flush_cnt;
`endif

   modport master (
      output id_valid, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
             id_rs1_data, id_rs2_data, id_imm, id_pc, id_ctrl, ex_flush, mem_busy,
      input  ID_EX_valid, ID_EX_rs1, ID_EX_rs2, ID_EX_rd, ID_EX_ctrl,
             ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm, ID_EX_pc,
             ID_EX_RegWrite, ID_EX_MemRead, stall_o
`ifdef HAZARD_STATS_EN
             , stall_cnt, flush_cnt
`endif
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
             id_rs1_data, id_rs2_data, id_imm, id_pc, id_ctrl, ex_flush, mem_busy,
      output ID_EX_valid, ID_EX_rs1, ID_EX_rs2, ID_EX_rd, ID_EX_ctrl,
             ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm, ID_EX_pc,
             ID_EX_RegWrite, ID_EX_MemRead, stall_o
`ifdef HAZARD_STATS_EN
             , stall_cnt, flush_cnt
`endif
   );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use detector: ID source depends on a load sitting in EX.
module hazard_detect
   import id_ex_stage_pkg::*;
(
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic             ex_valid,
   input  logic             ex_mem_read,
   input  logic [REG_W-1:0] ex_rd,
   output logic             load_use_c
);

   logic rs1_hit;
   logic rs2_hit;

   // x0 never creates a dependency; unused sources are ignored
   always_comb begin
      rs1_hit    = id_uses_rs1 && (id_rs1 == ex_rd);
      rs2_hit    = id_uses_rs2 && (id_rs2 == ex_rd);
      load_use_c = id_valid && ex_valid && ex_mem_read && (ex_rd != '0) &&
                   (rs1_hit || rs2_hit);
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and freeze.
// Optional feature: define HAZARD_STATS_EN to add stall_cnt/flush_cnt counters.
module id_ex_stage
   import id_ex_stage_pkg::*;
(
   input logic          clk,
   input logic          rst_n,
   id_ex_stage_if.slave bus
);

   id_ex_t q;
   id_ex_t d;
   logic   load_use_c;

   hazard_detect u_hazard_detect (
      .id_valid    (bus.id_valid),
      .id_rs1      (bus.id_rs1),
      .id_rs2      (bus.id_rs2),
      .id_uses_rs1 (bus.id_uses_rs1),
      .id_uses_rs2 (bus.id_uses_rs2),
      .ex_valid    (q.valid),
      .ex_mem_read (q.ctrl.mem_read),
      .ex_rd       (q.rd),
      .load_use_c  (load_use_c)
   );

   // Next payload: freeze on mem_busy, bubble on flush/load-use/empty slot
   always_comb begin
      d = q;
      if (!bus.mem_busy) begin
         if (bus.ex_flush || load_use_c || !bus.id_valid) begin
            d = '0;
         end else begin
            d.valid    = 1'b1;
            d.rs1      = bus.id_rs1;
            d.rs2      = bus.id_rs2;
            d.rd       = bus.id_rd;
            d.ctrl     = ctrl_t'(bus.id_ctrl);
            d.rs1_data = bus.id_rs1_data;
            d.rs2_data = bus.id_rs2_data;
            d.imm      = bus.id_imm;
            d.pc       = bus.id_pc;
         end
      end
   end

   // ID/EX register; reset value equals a bubble
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q <= '0;
      else        q <= d;
   end

   assign bus.ID_EX_valid    = q.valid;
   assign bus.ID_EX_rs1      = q.rs1;
   assign bus.ID_EX_rs2      = q.rs2;
   assign bus.ID_EX_rd       = q.rd;
   assign bus.ID_EX_ctrl     = CTRL_W'(q.ctrl);
   assign bus.ID_EX_rs1_data = q.rs1_data;
   assign bus.ID_EX_rs2_data = q.rs2_data;
   assign bus.ID_EX_imm      = q.imm;
   assign bus.ID_EX_pc       = q.pc;
   assign bus.ID_EX_RegWrite = q.ctrl.reg_write;
   assign bus.ID_EX_MemRead  = q.ctrl.mem_read;

   // Flush kills the stalled ID instruction, so it suppresses the load-use stall
   assign bus.stall_o = bus.mem_busy || (load_use_c && !bus.ex_flush);

`ifdef HAZARD_STATS_EN
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;

   // Saturating hazard counters, advancing only when the pipe moves
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (load_use_c && !bus.ex_flush && !bus.mem_busy && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (bus.ex_flush && !bus.mem_busy && (flush_cnt_q != '1))
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   assign bus.stall_cnt = stall_cnt_q;
   assign bus.flush_cnt = flush_cnt_q;
`endif

endmodule
